// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - Pi-driven stepper/DC dispense sequencer with req/ack handshake
//
// Purpose: synchronises the Pi GPIO inputs, runs manual jog modes while idle,
// and on a fresh candy_req rising edge issues exactly N stepper pulses with the
// DC agitator running, then completes a four-phase req/ack handshake.
//
// Optional feature macro: DISP_TIMEOUT_EN (dispense watchdog, drives fault).
//
// Ports:
//   clk        oscillator clock
//   rstn       asynchronous active-low reset
//   jog_mode   manual motor mode from Pi (asynchronous)
//   amount     dispense amount select from Pi (asynchronous)
//   candy_req  dispense request from Pi (asynchronous)
//   step_o     stepper STEP pin
//   dir_o      stepper DIR pin
//   dc_in1     DC H-bridge IN1
//   dc_in2     DC H-bridge IN2
//   dc_pwm     DC H-bridge enable PWM
//   ack        handshake to Pi
//   busy       high while dispensing
//   fault      watchdog fault flag (constant 0 without DISP_TIMEOUT_EN)
module dispense_sequencer #(
  parameter int STEP_DIV_FAST = 10,
  parameter int STEP_DIV_SLOW = 32,
  parameter int PWM_PERIOD    = 155,
  parameter int DUTY_SLOW     = 39,
  parameter int DUTY_FAST     = 116,
  parameter int DUTY_DISP     = 78,
  parameter int STEPS_SMALL   = 200,
  parameter int STEPS_MED     = 400,
  parameter int STEPS_LARGE   = 800,
`ifdef DISP_TIMEOUT_EN
  parameter int TIMEOUT_CLKS  = 65535,
`endif
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] jog_mode,
  input  logic [1:0] amount,
  input  logic       candy_req,
  output logic       step_o,
  output logic       dir_o,
  output logic       dc_in1,
  output logic       dc_in2,
  output logic       dc_pwm,
  output logic       ack,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE, ACK_CLR} state_t;

  state_t state, state_n;

  logic [2:0] jog_s1, jog_s2;
  logic [1:0] amt_s1, amt_s2;
  logic       req_s1, req_s2, req_prev;
  logic       req_rise;

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] amt_steps;
  logic [CNT_W-1:0] pwm_cnt;

  logic             step_en_n;
  logic [CNT_W-1:0] step_div_n;
  logic             dir_n, in1_n, in2_n;
  logic [CNT_W-1:0] duty_n;
  logic             disp_toggle;
  logic             entering;

  // The request chain resets high so a request already asserted at reset
  // release is not seen as a rising edge; a low-then-high is required.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      jog_s1   <= '0;
      jog_s2   <= '0;
      amt_s1   <= '0;
      amt_s2   <= '0;
      req_s1   <= 1'b1;
      req_s2   <= 1'b1;
      req_prev <= 1'b1;
    end else begin
      jog_s1   <= jog_mode;
      jog_s2   <= jog_s1;
      amt_s1   <= amount;
      amt_s2   <= amt_s1;
      req_s1   <= candy_req;
      req_s2   <= req_s1;
      req_prev <= req_s2;
    end
  end

  assign req_rise = req_s2 & ~req_prev;

  // Step generator toggle condition while dispensing (fixed fast divider);
  // kept independent of the next-state outputs to avoid a combinational loop.
  assign disp_toggle = (div_cnt >= CNT_W'(STEP_DIV_FAST - 1));
  assign entering    = (state == IDLE) && (state_n == DISPENSE);

  always_comb begin
    case (amt_s2)
      2'b00:   amt_steps = CNT_W'(STEPS_SMALL);
      2'b01:   amt_steps = CNT_W'(STEPS_MED);
      default: amt_steps = CNT_W'(STEPS_LARGE);
    endcase
  end

`ifdef DISP_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == DISPENSE) && (wd_cnt == CNT_W'(TIMEOUT_CLKS - 1));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_rise) state_n = DISPENSE;
      end
      DISPENSE: begin
        // Finish on the falling edge of the final step pulse.
        if (disp_toggle && step_o && (step_cnt == target)) state_n = DONE;
`ifdef DISP_TIMEOUT_EN
        if (timeout_hit) state_n = DONE;
`endif
      end
      DONE: begin
        if (!req_s2) state_n = ACK_CLR;
      end
      default: state_n = IDLE;
    endcase
  end

  // Motor settings are decoded from the next state so every output pin is a
  // plain register that changes on the same edge as the state.
  always_comb begin
    step_en_n  = 1'b0;
    step_div_n = CNT_W'(STEP_DIV_FAST);
    dir_n      = 1'b0;
    in1_n      = 1'b0;
    in2_n      = 1'b1;
    duty_n     = '0;
    case (state_n)
      IDLE: begin
        case (jog_s2)
          3'b001: begin
            step_en_n  = 1'b1;
            step_div_n = CNT_W'(STEP_DIV_SLOW);
          end
          3'b010: begin
            step_en_n  = 1'b1;
            step_div_n = CNT_W'(STEP_DIV_SLOW);
            dir_n      = 1'b1;
          end
          3'b011: begin
            step_en_n  = 1'b1;
          end
          3'b100: begin
            duty_n = CNT_W'(DUTY_SLOW);
          end
          3'b101: begin
            in1_n  = 1'b1;
            in2_n  = 1'b0;
            duty_n = CNT_W'(DUTY_SLOW);
          end
          3'b110: begin
            duty_n = CNT_W'(DUTY_FAST);
          end
          default: ;
        endcase
      end
      DISPENSE: begin
        step_en_n = 1'b1;
        in1_n     = 1'b1;
        in2_n     = 1'b0;
        duty_n    = CNT_W'(DUTY_DISP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt  <= '0;
      step_o   <= 1'b0;
      step_cnt <= '0;
      target   <= '0;
      pwm_cnt  <= '0;
      dc_pwm   <= 1'b0;
      dir_o    <= 1'b0;
      dc_in1   <= 1'b0;
      dc_in2   <= 1'b1;
      busy     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      // Entry into a dispense restarts the generator so pulse timing does not
      // depend on whatever jog was running in IDLE.
      if (!step_en_n || entering) begin
        div_cnt <= '0;
        step_o  <= 1'b0;
      end else if (div_cnt >= step_div_n - CNT_W'(1)) begin
        div_cnt <= '0;
        step_o  <= ~step_o;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end

      if (entering) begin
        step_cnt <= '0;
        target   <= amt_steps;
      end else if ((state == DISPENSE) && disp_toggle && !step_o && (step_cnt != '1)) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end

      if (pwm_cnt >= CNT_W'(PWM_PERIOD - 1)) pwm_cnt <= '0;
      else                                  pwm_cnt <= pwm_cnt + CNT_W'(1);
      dc_pwm <= (pwm_cnt < duty_n);

      dir_o  <= dir_n;
      dc_in1 <= in1_n;
      dc_in2 <= in2_n;
      busy   <= (state_n == DISPENSE);
      ack    <= (state_n == DONE);
    end
  end

`ifdef DISP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if (entering)                                    wd_cnt <= '0;
      else if ((state == DISPENSE) && (wd_cnt != '1))  wd_cnt <= wd_cnt + CNT_W'(1);

      if (timeout_hit)   fault <= 1'b1;
      else if (req_rise) fault <= 1'b0;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - self-checking bench for dispense_sequencer
module tb_dispense_sequencer;

  localparam int DIV_FAST = 2;
  localparam int DIV_SLOW = 4;
  localparam int PERIOD   = 10;
  localparam int D_SLOW   = 3;
  localparam int D_FAST   = 8;
  localparam int D_DISP   = 5;
  localparam int S_SMALL  = 5;
  localparam int S_MED    = 7;
  localparam int S_LARGE  = 9;

  logic       clk;
  logic       rstn;
  logic [2:0] jog_mode;
  logic [1:0] amount;
  logic       candy_req;
  logic       step_o, dir_o, dc_in1, dc_in2, dc_pwm, ack, busy, fault;

  int n_cmp = 0;
  int n_err = 0;

  dispense_sequencer #(
    .STEP_DIV_FAST(DIV_FAST),
    .STEP_DIV_SLOW(DIV_SLOW),
    .PWM_PERIOD   (PERIOD),
    .DUTY_SLOW    (D_SLOW),
    .DUTY_FAST    (D_FAST),
    .DUTY_DISP    (D_DISP),
    .STEPS_SMALL  (S_SMALL),
    .STEPS_MED    (S_MED),
    .STEPS_LARGE  (S_LARGE),
    .CNT_W        (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .jog_mode (jog_mode),
    .amount   (amount),
    .candy_req(candy_req),
    .step_o   (step_o),
    .dir_o    (dir_o),
    .dc_in1   (dc_in1),
    .dc_in2   (dc_in2),
    .dc_pwm   (dc_pwm),
    .ack      (ack),
    .busy     (busy),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_step"},  32'(step_o), 0);
    check({tag, "_dir"},   32'(dir_o),  0);
    check({tag, "_in1"},   32'(dc_in1), 0);
    check({tag, "_in2"},   32'(dc_in2), 1);
    check({tag, "_pwm"},   32'(dc_pwm), 0);
    check({tag, "_ack"},   32'(ack),    0);
    check({tag, "_busy"},  32'(busy),   0);
    check({tag, "_fault"}, 32'(fault),  0);
  endtask

  // Reference: steps for an amount code.
  function automatic int model_steps(input logic [1:0] a);
    if (a == 2'b00) return S_SMALL;
    if (a == 2'b01) return S_MED;
    return S_LARGE;
  endfunction

  // Reference: jog behaviour as (dir, step period in clocks or 0, in1, in2, pwm duty).
  task automatic model_jog(input logic [2:0] m, output int dir, output int per,
                           output int in1, output int in2, output int duty);
    dir = 0; per = 0; in1 = 0; in2 = 1; duty = 0;
    case (m)
      3'd1: per = 2 * DIV_SLOW;
      3'd2: begin per = 2 * DIV_SLOW; dir = 1; end
      3'd3: per = 2 * DIV_FAST;
      3'd4: duty = D_SLOW;
      3'd5: begin in1 = 1; in2 = 0; duty = D_SLOW; end
      3'd6: duty = D_FAST;
      default: ;
    endcase
  endtask

  task automatic run_jog(input logic [2:0] m);
    int e_dir, e_per, e_in1, e_in2, e_duty;
    int highs, rises, cyc;
    logic prev;
    bit found;
    model_jog(m, e_dir, e_per, e_in1, e_in2, e_duty);
    jog_mode = m;
    repeat (5) tick();
    check($sformatf("jog%0d_dir", m), 32'(dir_o),  32'(e_dir));
    check($sformatf("jog%0d_in1", m), 32'(dc_in1), 32'(e_in1));
    check($sformatf("jog%0d_in2", m), 32'(dc_in2), 32'(e_in2));
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      highs += int'(dc_pwm);
      tick();
    end
    check($sformatf("jog%0d_pwm_high", m), 32'(highs), 32'(e_duty));
    if (e_per > 0) begin
      found = 0;
      prev = step_o;
      for (int i = 0; i < 3 * e_per && !found; i++) begin
        tick();
        if (step_o && !prev) found = 1;
        prev = step_o;
      end
      cyc = 0;
      if (found) begin
        found = 0;
        for (int i = 0; i < 3 * e_per && !found; i++) begin
          tick();
          cyc++;
          if (step_o && !prev) found = 1;
          prev = step_o;
        end
      end
      check($sformatf("jog%0d_step_period", m), 32'(found ? cyc : -1), 32'(e_per));
    end else begin
      rises = 0;
      prev = step_o;
      check($sformatf("jog%0d_step_idle", m), 32'(step_o), 0);
      for (int i = 0; i < 20; i++) begin
        tick();
        if (step_o && !prev) rises++;
        prev = step_o;
      end
      check($sformatf("jog%0d_step_rises", m), 32'(rises), 0);
    end
  endtask

  task automatic run_dispense(input logic [1:0] a, input bit drop_mid);
    int e_steps, busy_cyc, rises, bad, highs, drop_at, extra_busy;
    logic prev;
    e_steps = model_steps(a);
    amount = a;
    jog_mode = 3'($urandom_range(0, 7));
    candy_req = 1'b1;
    tick();
    tick();
    check("latency_busy_early", 32'(busy), 0);
    tick();
    check("latency_busy_at3", 32'(busy), 1);
    busy_cyc = 0; rises = 0; bad = 0; highs = 0;
    drop_at = $urandom_range(1, 15);
    prev = step_o;
    while (busy === 1'b1 && busy_cyc < 2000) begin
      busy_cyc++;
      if (step_o && !prev) rises++;
      prev = step_o;
      if (dir_o !== 1'b0 || dc_in1 !== 1'b1 || dc_in2 !== 1'b0) bad++;
      if (busy_cyc <= 2 * PERIOD) highs += int'(dc_pwm);
      if (busy_cyc % 3 == 0) jog_mode = 3'($urandom_range(0, 7));
      if (drop_mid && busy_cyc == drop_at) candy_req = 1'b0;
      tick();
    end
    check($sformatf("disp_a%0d_cycles", a), 32'(busy_cyc), 32'(e_steps * 2 * DIV_FAST));
    check($sformatf("disp_a%0d_rises", a),  32'(rises),    32'(e_steps));
    check("disp_pins_bad", 32'(bad), 0);
    check("disp_pwm_high", 32'(highs), 32'(2 * D_DISP));
    check("done_ack", 32'(ack), 1);
    check("done_step", 32'(step_o), 0);
    check("done_in1", 32'(dc_in1), 0);
    check("done_in2", 32'(dc_in2), 1);
    check("done_pwm", 32'(dc_pwm), 0);
    check("done_fault", 32'(fault), 0);
    if (!drop_mid) begin
      extra_busy = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        extra_busy += int'(busy);
      end
      check("hold_req_no_redispense", 32'(extra_busy), 0);
      check("hold_req_ack", 32'(ack), 1);
      candy_req = 1'b0;
    end
    for (int i = 0; i < 6 && ack === 1'b1; i++) tick();
    check("ack_release", 32'(ack), 0);
    check("ack_release_busy", 32'(busy), 0);
    repeat (3) tick();
  endtask

  initial begin
    int extra_busy;
    rstn = 1'b0;
    jog_mode = 3'b000;
    amount = 2'b00;
    candy_req = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    rstn = 1'b1;
    repeat (3) tick();
    check_reset("post_reset");

    run_jog(3'b010);
    for (int i = 0; i < 6; i++) run_jog(3'($urandom_range(0, 7)));
    run_jog(3'b000);

    run_dispense(2'b00, 1'b0);
    run_dispense(2'b11, 1'b0);
    for (int i = 0; i < 5; i++)
      run_dispense(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a dispense, with the request held
    // high through reset release.
    amount = 2'($urandom_range(0, 3));
    candy_req = 1'b1;
    repeat (3) tick();
    check("pre_reset_busy", 32'(busy), 1);
    repeat (5) tick();
    #2;
    rstn = 1'b0;
    #1;
    check_reset("async_reset");
    tick();
    rstn = 1'b1;
    extra_busy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      extra_busy += int'(busy);
    end
    check("req_high_at_release_busy", 32'(extra_busy), 0);
    check("req_high_at_release_ack", 32'(ack), 0);
    candy_req = 1'b0;
    repeat (4) tick();
    run_dispense(2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
